// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_pkg
// Brief    : Shared types, derived geometry and address helpers for the
//            data cache storage (2-way, 128 sets, 16-byte blocks).
// Revision : 1.0 - initial release
// ============================================================================
package data_memory_pkg;

  localparam int ADDR_BITS       = 32;
  localparam int WORD_BITS       = 32;
  localparam int BE_BITS         = WORD_BITS / 8;
  localparam int NUM_WAYS        = 2;
  localparam int BLOCK_BYTES     = 16;
  localparam int SETS            = 4096 / (BLOCK_BYTES * NUM_WAYS);
  localparam int BYTE_SEL_WIDTH  = $clog2(BE_BITS);
  localparam int WORD_SEL_WIDTH  = $clog2(BLOCK_BYTES / BE_BITS);
  localparam int OFFSET_WIDTH    = BYTE_SEL_WIDTH + WORD_SEL_WIDTH;
  localparam int INDEX_WIDTH     = $clog2(SETS);
  localparam int TAG_WIDTH       = ADDR_BITS - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WAY_ADDR        = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int WORDS_PER_BLOCK = 1 << WORD_SEL_WIDTH;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_WIDTH-1:0] tag;
    logic [WORD_BITS-1:0] word;
  } data_cache_packet_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]      tag;
    logic [INDEX_WIDTH-1:0]    index;
    logic [WORD_SEL_WIDTH-1:0] word;
    logic [BYTE_SEL_WIDTH-1:0] byte_off;
  } addr_fields_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_t;

  // Split a byte address into tag / set index / word select / byte offset.
  function automatic addr_fields_t split_addr(input logic [ADDR_BITS-1:0] addr);
    return addr_fields_t'(addr);
  endfunction

  // Replace only the enabled bytes of old_word with those of new_word.
  function automatic logic [WORD_BITS-1:0] merge_bytes(
    input logic [WORD_BITS-1:0] old_word,
    input logic [WORD_BITS-1:0] new_word,
    input logic [BE_BITS-1:0]   byte_en
  );
    logic [WORD_BITS-1:0] result;
    result = old_word;
    for (int b = 0; b < BE_BITS; b++) begin
      if (byte_en[b]) result[8*b +: 8] = new_word[8*b +: 8];
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_cache_way.sv
`default_nettype none
// ============================================================================
// Module   : data_cache_way
// Brief    : One cache way: tag, valid, dirty and data arrays with one
//            write port, one set-clear port and two asynchronous read ports.
// Revision : 1.0 - initial release
// ============================================================================
module data_cache_way
  import data_memory_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      clear_i,
  input  logic [INDEX_WIDTH-1:0]    clear_index_i,
  input  logic                      write_i,
  input  logic [INDEX_WIDTH-1:0]    write_index_i,
  input  logic [WORD_SEL_WIDTH-1:0] write_word_i,
  input  logic [BE_BITS-1:0]        write_byte_en_i,
  input  data_cache_packet_t        write_packet_i,
  input  logic [INDEX_WIDTH-1:0]    rd0_index_i,
  input  logic [WORD_SEL_WIDTH-1:0] rd0_word_i,
  output data_cache_packet_t        rd0_packet_o,
  input  logic [INDEX_WIDTH-1:0]    rd1_index_i,
  input  logic [WORD_SEL_WIDTH-1:0] rd1_word_i,
  output data_cache_packet_t        rd1_packet_o
);

  logic [TAG_WIDTH-1:0] tag_mem  [SETS];
  logic [WORD_BITS-1:0] data_mem [SETS*WORDS_PER_BLOCK];
  logic [SETS-1:0]      valid_q, valid_d;
  logic [SETS-1:0]      dirty_q, dirty_d;

  // Status bits: sweep clears a set, a write loads the controller's status.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (clear_i) begin
      valid_d[clear_index_i] = 1'b0;
      dirty_d[clear_index_i] = 1'b0;
    end
    if (write_i) begin
      valid_d[write_index_i] = write_packet_i.valid;
      dirty_d[write_index_i] = write_packet_i.dirty;
    end
  end

  // Status register update; the owner's reset triggers a clearing sweep.
  always_ff @(posedge clk_i) begin
    valid_q <= valid_d;
    dirty_q <= dirty_d;
  end

  // Tag write plus byte-enabled data word write.
  always_ff @(posedge clk_i) begin
    if (write_i) begin
      tag_mem[write_index_i] <= write_packet_i.tag;
      for (int b = 0; b < BE_BITS; b++) begin
        if (write_byte_en_i[b]) begin
          data_mem[{write_index_i, write_word_i}][8*b +: 8] <= write_packet_i.word[8*b +: 8];
        end
      end
    end
  end

  // Asynchronous reads; the top registers the selected result.
  always_comb begin
    rd0_packet_o.valid = valid_q[rd0_index_i];
    rd0_packet_o.dirty = dirty_q[rd0_index_i];
    rd0_packet_o.tag   = tag_mem[rd0_index_i];
    rd0_packet_o.word  = data_mem[{rd0_index_i, rd0_word_i}];
    rd1_packet_o.valid = valid_q[rd1_index_i];
    rd1_packet_o.dirty = dirty_q[rd1_index_i];
    rd1_packet_o.tag   = tag_mem[rd1_index_i];
    rd1_packet_o.word  = data_mem[{rd1_index_i, rd1_word_i}];
  end

endmodule
`default_nettype wire

// File: rtl/data_cache_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_cache_memory
// Brief    : Dual-port set-associative data cache storage. Port0 read/write
//            (store side), port1 read-only (load side), registered hit and
//            packet one cycle after each request, invalidate sweep FSM.
// Options  : DCACHE_WRITE_FORWARD_EN - forward a same-cycle port0 write to
//            a port1 read of the same index/word/way.
// Revision : 1.0 - initial release
// ============================================================================
module data_cache_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int PORT_WIDTH = 32,
  parameter int CACHE_SIZE = 4096,
  parameter int BLOCK_SIZE = 16,
  parameter int WAYS       = 2
)(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    invalidate_i,
  output logic                    busy_o,
  output logic                    invalidate_done_o,
  input  logic [ADDR_WIDTH-1:0]   port0_address_i,
  input  logic                    port0_read_i,
  input  logic                    port0_write_i,
  input  logic [WAY_ADDR-1:0]     port0_way_i,
  input  logic [PORT_WIDTH/8-1:0] port0_byte_en_i,
  input  data_cache_packet_t      port0_packet_i,
  output logic                    port0_valid_o,
  output logic                    port0_hit_o,
  output logic [WAY_ADDR-1:0]     port0_hit_way_o,
  output data_cache_packet_t      port0_packet_o,
  input  logic [ADDR_WIDTH-1:0]   port1_address_i,
  input  logic                    port1_read_i,
  output logic                    port1_valid_o,
  output logic                    port1_hit_o,
  output data_cache_packet_t      port1_packet_o
);

  localparam int                     SWEEP_SETS = CACHE_SIZE / (BLOCK_SIZE * WAYS);
  localparam logic [INDEX_WIDTH-1:0] LAST_SET   = INDEX_WIDTH'(SWEEP_SETS - 1);

  sweep_state_t           state_q, state_d;
  logic [INDEX_WIDTH-1:0] counter_q, counter_d;
  logic                   sweep_clear, sweep_done;

  addr_fields_t p0_addr, p1_addr;
  logic         unused_byte_bits;
  logic         idle, wr_en, p0_rd, p1_rd;

  data_cache_packet_t way_p0_pkt [WAYS];
  data_cache_packet_t way_p1_raw [WAYS];
  data_cache_packet_t way_p1_pkt [WAYS];

  logic               p0_hit, p1_hit;
  logic [WAY_ADDR-1:0] p0_way;
  data_cache_packet_t p0_sel, p1_sel;

  logic               p0_valid_q, p0_valid_d, p0_hit_q, p0_hit_d;
  logic [WAY_ADDR-1:0] p0_way_q, p0_way_d;
  data_cache_packet_t p0_pkt_q, p0_pkt_d;
  logic               p1_valid_q, p1_valid_d, p1_hit_q, p1_hit_d;
  data_cache_packet_t p1_pkt_q, p1_pkt_d;

  assign p0_addr          = split_addr(port0_address_i);
  assign p1_addr          = split_addr(port1_address_i);
  assign unused_byte_bits = ^{p0_addr.byte_off, p1_addr.byte_off};

  // Requests are only honoured outside the sweep; a write drops a same-port read.
  assign idle  = (state_q == ST_IDLE);
  assign wr_en = idle & port0_write_i;
  assign p0_rd = idle & port0_read_i & ~port0_write_i;
  assign p1_rd = idle & port1_read_i;

  // Sweep FSM next state: one set cleared per cycle, done on the last set.
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    sweep_clear = 1'b0;
    sweep_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (invalidate_i) begin
          state_d   = ST_SWEEP;
          counter_d = '0;
        end
      end
      ST_SWEEP: begin
        sweep_clear = 1'b1;
        counter_d   = counter_q + 1'b1;
        if (counter_q == LAST_SET) begin
          sweep_done = 1'b1;
          state_d    = ST_IDLE;
          counter_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sweep FSM registers; reset (re)starts the sweep from set 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_SWEEP;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  assign busy_o            = (state_q == ST_SWEEP);
  assign invalidate_done_o = sweep_done;

  generate
    for (genvar w = 0; w < WAYS; w++) begin : g_way
      data_cache_way u_way (
        .clk_i           (clk_i),
        .clear_i         (sweep_clear),
        .clear_index_i   (counter_q),
        .write_i         (wr_en && (port0_way_i == WAY_ADDR'(w))),
        .write_index_i   (p0_addr.index),
        .write_word_i    (p0_addr.word),
        .write_byte_en_i (port0_byte_en_i),
        .write_packet_i  (port0_packet_i),
        .rd0_index_i     (p0_addr.index),
        .rd0_word_i      (p0_addr.word),
        .rd0_packet_o    (way_p0_pkt[w]),
        .rd1_index_i     (p1_addr.index),
        .rd1_word_i      (p1_addr.word),
        .rd1_packet_o    (way_p1_raw[w])
      );
    end
  endgenerate

  // Port1 view of each way, optionally bypassing a same-cycle port0 write.
  always_comb begin
    for (int w = 0; w < WAYS; w++) way_p1_pkt[w] = way_p1_raw[w];
`ifdef DCACHE_WRITE_FORWARD_EN
    if (wr_en && p1_rd && (p0_addr.index == p1_addr.index) && (p0_addr.word == p1_addr.word)) begin
      way_p1_pkt[port0_way_i].valid = port0_packet_i.valid;
      way_p1_pkt[port0_way_i].dirty = port0_packet_i.dirty;
      way_p1_pkt[port0_way_i].tag   = port0_packet_i.tag;
      way_p1_pkt[port0_way_i].word  = merge_bytes(way_p1_raw[port0_way_i].word,
                                                  port0_packet_i.word, port0_byte_en_i);
    end
`endif
  end

  // Hit detection; iterating downwards lets the lowest matching way win.
  always_comb begin
    p0_hit = 1'b0;
    p0_way = '0;
    p0_sel = way_p0_pkt[0];
    p1_hit = 1'b0;
    p1_sel = way_p1_pkt[0];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_p0_pkt[w].valid && (way_p0_pkt[w].tag == p0_addr.tag)) begin
        p0_hit = 1'b1;
        p0_way = WAY_ADDR'(w);
        p0_sel = way_p0_pkt[w];
      end
      if (way_p1_pkt[w].valid && (way_p1_pkt[w].tag == p1_addr.tag)) begin
        p1_hit = 1'b1;
        p1_sel = way_p1_pkt[w];
      end
    end
  end

  // Response capture: strobe pulses per request, result held until the next one.
  always_comb begin
    p0_valid_d = p0_rd;
    p0_hit_d   = p0_hit_q;
    p0_way_d   = p0_way_q;
    p0_pkt_d   = p0_pkt_q;
    p1_valid_d = p1_rd;
    p1_hit_d   = p1_hit_q;
    p1_pkt_d   = p1_pkt_q;
    if (p0_rd) begin
      p0_hit_d = p0_hit;
      p0_way_d = p0_way;
      p0_pkt_d = p0_sel;
    end
    if (p1_rd) begin
      p1_hit_d = p1_hit;
      p1_pkt_d = p1_sel;
    end
  end

  // Response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p0_valid_q <= 1'b0;
      p0_hit_q   <= 1'b0;
      p0_way_q   <= '0;
      p0_pkt_q   <= '0;
      p1_valid_q <= 1'b0;
      p1_hit_q   <= 1'b0;
      p1_pkt_q   <= '0;
    end else begin
      p0_valid_q <= p0_valid_d;
      p0_hit_q   <= p0_hit_d;
      p0_way_q   <= p0_way_d;
      p0_pkt_q   <= p0_pkt_d;
      p1_valid_q <= p1_valid_d;
      p1_hit_q   <= p1_hit_d;
      p1_pkt_q   <= p1_pkt_d;
    end
  end

  assign port0_valid_o   = p0_valid_q;
  assign port0_hit_o     = p0_hit_q;
  assign port0_hit_way_o = p0_way_q;
  assign port0_packet_o  = p0_pkt_q;
  assign port1_valid_o   = p1_valid_q;
  assign port1_hit_o     = p1_hit_q;
  assign port1_packet_o  = p1_pkt_q;

endmodule
`default_nettype wire

// File: tb/tb_data_cache_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache_memory
// Brief    : Scoreboard bench for data_cache_memory: directed requests push
//            expected responses, a monitor pops them on each valid strobe.
//            Honours DCACHE_WRITE_FORWARD_EN for the same-cycle case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache_memory;
  import data_memory_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_i, invalidate_i;
  logic               busy_o, invalidate_done_o;
  logic [31:0]        port0_address_i, port1_address_i;
  logic               port0_read_i, port0_write_i, port1_read_i;
  logic [0:0]         port0_way_i;
  logic [3:0]         port0_byte_en_i;
  data_cache_packet_t port0_packet_i, port0_packet_o, port1_packet_o;
  logic               port0_valid_o, port0_hit_o, port1_valid_o, port1_hit_o;
  logic [0:0]         port0_hit_way_o;

  data_cache_memory dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .invalidate_i      (invalidate_i),
    .busy_o            (busy_o),
    .invalidate_done_o (invalidate_done_o),
    .port0_address_i   (port0_address_i),
    .port0_read_i      (port0_read_i),
    .port0_write_i     (port0_write_i),
    .port0_way_i       (port0_way_i),
    .port0_byte_en_i   (port0_byte_en_i),
    .port0_packet_i    (port0_packet_i),
    .port0_valid_o     (port0_valid_o),
    .port0_hit_o       (port0_hit_o),
    .port0_hit_way_o   (port0_hit_way_o),
    .port0_packet_o    (port0_packet_o),
    .port1_address_i   (port1_address_i),
    .port1_read_i      (port1_read_i),
    .port1_valid_o     (port1_valid_o),
    .port1_hit_o       (port1_hit_o),
    .port1_packet_o    (port1_packet_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        hit;
    logic        way;
    logic        chk_pkt;
    logic [31:0] word;
    logic        dirty;
    logic [20:0] tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   errors = 0;
  int   n_cyc, done_at;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic h, input logic w, input logic c,
                              input logic [31:0] wd, input logic d, input logic [20:0] t);
    exp_t e;
    e.hit = h; e.way = w; e.chk_pkt = c; e.word = wd; e.dirty = d; e.tag = t;
    return e;
  endfunction

  function automatic data_cache_packet_t pkt(input logic v, input logic d,
                                             input logic [20:0] t, input logic [31:0] w);
    data_cache_packet_t p;
    p.valid = v; p.dirty = d; p.tag = t; p.word = w;
    return p;
  endfunction

  // Monitor: every response strobe must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (port0_valid_o) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL p0_unexpected_valid: got valid=1 expected no response");
      end else begin
        e0 = q0.pop_front();
        check("p0_hit", 64'(port0_hit_o), 64'(e0.hit));
        if (e0.hit) check("p0_hit_way", 64'(port0_hit_way_o), 64'(e0.way));
        if (e0.chk_pkt) begin
          check("p0_word",  64'(port0_packet_o.word),  64'(e0.word));
          check("p0_dirty", 64'(port0_packet_o.dirty), 64'(e0.dirty));
          check("p0_tag",   64'(port0_packet_o.tag),   64'(e0.tag));
        end
      end
    end
    if (port1_valid_o) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL p1_unexpected_valid: got valid=1 expected no response");
      end else begin
        e1 = q1.pop_front();
        check("p1_hit", 64'(port1_hit_o), 64'(e1.hit));
        if (e1.chk_pkt) begin
          check("p1_word",  64'(port1_packet_o.word),  64'(e1.word));
          check("p1_dirty", 64'(port1_packet_o.dirty), 64'(e1.dirty));
          check("p1_tag",   64'(port1_packet_o.tag),   64'(e1.tag));
        end
      end
    end
  end

  task automatic drive(input logic p0r, input logic p0w, input logic [31:0] a0, input logic wy,
                       input logic [3:0] be, input data_cache_packet_t pk,
                       input logic p1r, input logic [31:0] a1);
    @(posedge clk_i); #1;
    port0_read_i = p0r; port0_write_i = p0w; port0_address_i = a0; port0_way_i = wy;
    port0_byte_en_i = be; port0_packet_i = pk; port1_read_i = p1r; port1_address_i = a1;
    invalidate_i = 1'b0;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, '0, 1'b0, 32'h0);
  endtask

  task automatic start_invalidate();
    @(posedge clk_i); #1 invalidate_i = 1'b1;
    @(posedge clk_i); #1 invalidate_i = 1'b0;
    @(negedge clk_i);
  endtask

  // Count busy cycles from the current negedge; mode 1 injects dropped
  // requests and a second invalidate, mode 2 pulses reset mid-sweep.
  task automatic sweep_count(input int mode, output int n, output int done_seen);
    n = 0;
    done_seen = -1;
    while (busy_o && n < 1000) begin
      n++;
      if (invalidate_done_o) done_seen = (done_seen < 0) ? n : -2;
      if (mode == 1 && n == 50) begin
        port0_read_i = 1'b1; port0_write_i = 1'b1; port0_address_i = 32'h0000_0040;
        port0_way_i = 1'b0; port0_byte_en_i = 4'hF;
        port0_packet_i = pkt(1'b1, 1'b0, 21'h0, 32'hCAFE_F00D);
        port1_read_i = 1'b1; port1_address_i = 32'h0000_1234;
      end
      if (mode == 1 && n == 51) begin
        port0_read_i = 1'b1; port0_write_i = 1'b0; port1_read_i = 1'b1;
      end
      if (mode == 1 && n == 52) begin
        port0_read_i = 1'b0; port1_read_i = 1'b0;
      end
      if (mode == 1 && n == 60) invalidate_i = 1'b1;
      if (mode == 1 && n == 61) invalidate_i = 1'b0;
      if (mode == 2 && n == 40) rst_i = 1'b1;
      if (mode == 2 && n == 41) rst_i = 1'b0;
      @(negedge clk_i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; invalidate_i = 1'b0;
    port0_read_i = 1'b0; port0_write_i = 1'b0; port0_address_i = '0; port0_way_i = '0;
    port0_byte_en_i = '0; port0_packet_i = '0; port1_read_i = 1'b0; port1_address_i = '0;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);

    // Reset state
    check("rst_p0_valid", 64'(port0_valid_o), 64'd0);
    check("rst_p0_hit", 64'(port0_hit_o), 64'd0);
    check("rst_p0_hit_way", 64'(port0_hit_way_o), 64'd0);
    check("rst_p0_packet", 64'(port0_packet_o), 64'd0);
    check("rst_p1_valid", 64'(port1_valid_o), 64'd0);
    check("rst_p1_hit", 64'(port1_hit_o), 64'd0);
    check("rst_p1_packet", 64'(port1_packet_o), 64'd0);
    check("rst_done", 64'(invalidate_done_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd1);

    sweep_count(0, n_cyc, done_at);
    check("reset_sweep_len", 64'(n_cyc), 64'd128);
    check("reset_sweep_done_at", 64'(done_at), 64'd128);

    // Write way1 @0x1234 (tag 2, index 0x23, word 1), then read on both ports.
    drive(1'b0, 1'b1, 32'h0000_1234, 1'b1, 4'hF, pkt(1'b1, 1'b0, 21'd2, 32'hDEAD_BEEF), 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_1234, 1'b0, 4'h0, '0, 1'b1, 32'h0000_1234);
    q0.push_back(mk(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 21'd2));
    q1.push_back(mk(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 21'd2));

    // Same index, different tag -> miss.
    drive(1'b1, 1'b0, 32'h0000_5234, 1'b0, 4'h0, '0, 1'b1, 32'h0000_5234);
    q0.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 21'd0));
    q1.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 21'd0));

    // Byte-1 write only: 0xDEADBEEF -> 0xDEADAAEF, dirty set.
    drive(1'b0, 1'b1, 32'h0000_1234, 1'b1, 4'b0010, pkt(1'b1, 1'b1, 21'd2, 32'h0000_AA00), 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_1234, 1'b0, 4'h0, '0, 1'b1, 32'h0000_1234);
    q0.push_back(mk(1'b1, 1'b1, 1'b1, 32'hDEAD_AAEF, 1'b1, 21'd2));
    q1.push_back(mk(1'b1, 1'b0, 1'b1, 32'hDEAD_AAEF, 1'b1, 21'd2));

    // Same tag now valid in way0 too: lowest way wins.
    drive(1'b0, 1'b1, 32'h0000_1234, 1'b0, 4'hF, pkt(1'b1, 1'b0, 21'd2, 32'h0123_4567), 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_1234, 1'b0, 4'h0, '0, 1'b1, 32'h0000_1234);
    q0.push_back(mk(1'b1, 1'b0, 1'b1, 32'h0123_4567, 1'b0, 21'd2));
    q1.push_back(mk(1'b1, 1'b0, 1'b1, 32'h0123_4567, 1'b0, 21'd2));

    // Same-cycle port0 write (+ dropped port0 read) and port1 read of that word.
    drive(1'b1, 1'b1, 32'h0000_1234, 1'b0, 4'hF, pkt(1'b1, 1'b1, 21'd2, 32'h1111_1111), 1'b1, 32'h0000_1234);
`ifdef DCACHE_WRITE_FORWARD_EN
    q1.push_back(mk(1'b1, 1'b0, 1'b1, 32'h1111_1111, 1'b1, 21'd2));
`else
    q1.push_back(mk(1'b1, 1'b0, 1'b1, 32'h0123_4567, 1'b0, 21'd2));
`endif
    drive(1'b1, 1'b0, 32'h0000_1234, 1'b0, 4'h0, '0, 1'b1, 32'h0000_1234);
    q0.push_back(mk(1'b1, 1'b0, 1'b1, 32'h1111_1111, 1'b1, 21'd2));
    q1.push_back(mk(1'b1, 1'b0, 1'b1, 32'h1111_1111, 1'b1, 21'd2));
    idle_cycle();

    // Invalidate sweep with dropped requests and an ignored re-invalidate.
    start_invalidate();
    sweep_count(1, n_cyc, done_at);
    check("inv_sweep_len", 64'(n_cyc), 64'd128);
    check("inv_sweep_done_at", 64'(done_at), 64'd128);
    drive(1'b1, 1'b0, 32'h0000_1234, 1'b0, 4'h0, '0, 1'b1, 32'h0000_1234);
    q0.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 21'd0));
    q1.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 21'd0));
    drive(1'b1, 1'b0, 32'h0000_0040, 1'b0, 4'h0, '0, 1'b0, 32'h0);
    q0.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 21'd0));
    idle_cycle();

    // Reset in the middle of a sweep restarts it from set 0.
    start_invalidate();
    sweep_count(2, n_cyc, done_at);
    check("rst_mid_sweep_len", 64'(n_cyc), 64'd168);
    check("rst_mid_sweep_done_at", 64'(done_at), 64'd168);
    drive(1'b1, 1'b0, 32'h0000_1234, 1'b0, 4'h0, '0, 1'b1, 32'h0000_1234);
    q0.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 21'd0));
    q1.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 21'd0));
    idle_cycle();
    idle_cycle();
    idle_cycle();
    @(negedge clk_i);

    check("p0_outstanding", 64'(q0.size()), 64'd0);
    check("p1_outstanding", 64'(q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
